cpu_seq_core: RTL and testbench

Parametrised multi-cycle CPU core that replaces the fixed single-state controller in the tt_um top. It fetches 8-bit instructions and optional immediates over a valid/ready byte-stream port. It sequences them through an explicit FETCH/IMM/EXEC/WB state machine over a 4-entry register file, a flag-producing ALU and a DATA_W-wide datapath, and exposes R0, the flags and the PC to the pins.

---
 rtl/cpu_seq_core.sv | 116 +++++++++++
 tb/tb_cpu_seq_core.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_core.sv
// Multi-cycle CPU core: FETCH/IMM/EXEC/WB sequencer, 4-entry register file, flag ALU.
// Optional macro CPU_SEQ_JZ_EN: opcode 111 is a conditional JZ; when undefined it is a NOP.
module cpu_seq_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] instr_data,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] out_data,
  output logic              flag_z,
  output logic              flag_c,
  output logic [1:0]        state,
  output logic              wb_valid
);
  localparam int XW = (PC_W > DATA_W) ? PC_W : DATA_W;

  typedef enum logic [1:0] {S_FETCH = 2'b00, S_IMM = 2'b01, S_EXEC = 2'b10, S_WB = 2'b11} state_t;

  state_t                  st;
  logic [7:0]              ir;
  logic [DATA_W-1:0]       imm;
  logic [3:0][DATA_W-1:0]  rf;
  logic [DATA_W-1:0]       res;
  logic                    res_z, res_c;
  logic [PC_W-1:0]         jt;

  logic [2:0]              op;
  logic [DATA_W-1:0]       rd_val, src, alu_res;
  logic [DATA_W:0]         sum, dif;
  logic                    alu_c;
  logic [XW-1:0]           src_x;

  assign op          = ir[7:5];
  assign rd_val      = rf[ir[4:3]];
  assign src         = ir[0] ? imm : rf[ir[2:1]];
  assign sum         = {1'b0, rd_val} + {1'b0, src};
  assign dif         = {1'b0, rd_val} - {1'b0, src};
  assign src_x       = XW'(src);
  assign instr_ready = (st == S_FETCH) || (st == S_IMM);
  assign state       = st;
  assign out_data    = rf[0];

  // Borrow of the unsigned subtract is the extra top bit of the widened difference.
  always_comb begin
    alu_res = src;
    alu_c   = 1'b0;
    case (op)
      3'b000:  begin alu_res = sum[DATA_W-1:0]; alu_c = sum[DATA_W]; end
      3'b001:  begin alu_res = dif[DATA_W-1:0]; alu_c = dif[DATA_W]; end
      3'b010:  alu_res = rd_val & src;
      3'b011:  alu_res = rd_val | src;
      3'b100:  alu_res = rd_val ^ src;
      default: alu_res = src;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      imm      <= '0;
      rf       <= '0;
      res      <= '0;
      res_z    <= 1'b0;
      res_c    <= 1'b0;
      jt       <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      wb_valid <= 1'b0;
    end else begin
      case (st)
        S_FETCH: if (instr_valid) begin
          ir <= instr_data[7:0];
          pc <= pc + PC_W'(1);
          st <= instr_data[0] ? S_IMM : S_EXEC;
        end
        S_IMM: if (instr_valid) begin
          imm <= instr_data;
          pc  <= pc + PC_W'(1);
          st  <= S_EXEC;
        end
        S_EXEC: begin
          res      <= alu_res;
          res_z    <= (alu_res == '0);
          res_c    <= alu_c;
          jt       <= src_x[PC_W-1:0];
          wb_valid <= 1'b1;
          st       <= S_WB;
        end
        S_WB: begin
          wb_valid <= 1'b0;
          st       <= S_FETCH;
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b100: begin
              rf[ir[4:3]] <= res;
              flag_z      <= res_z;
              flag_c      <= res_c;
            end
            3'b101: rf[ir[4:3]] <= res;
            3'b110: pc <= jt;
`ifdef CPU_SEQ_JZ_EN
            3'b111: if (flag_z) pc <= jt;
`endif
            default: ;
          endcase
        end
        default: st <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_seq_core.sv
// Directed, table-driven bench for cpu_seq_core plus hand sequences for stalls, pc wrap and reset.
module tb_cpu_seq_core;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] instr_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] pc;
  logic [7:0] out_data;
  logic       flag_z, flag_c;
  logic [1:0] state;
  logic       wb_valid;

  int checks = 0;
  int failures = 0;

`ifdef CPU_SEQ_JZ_EN
  localparam logic [7:0] B = 8'h10;
`else
  localparam logic [7:0] B = 8'h07;
`endif

  cpu_seq_core #(.DATA_W(8), .PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr_data(instr_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .out_data(out_data), .flag_z(flag_z),
    .flag_c(flag_c), .state(state), .wb_valid(wb_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op;
    logic       hi;
    logic [7:0] im;
    logic [7:0] e_out;
    logic       e_z;
    logic       e_c;
    logic [7:0] e_pc;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge in FETCH; returns cycles from the handshake cycle to the WB cycle.
  task automatic run_instr(input logic [7:0] op, input logic [7:0] im, output int n);
    instr_data  = op;
    instr_valid = 1'b1;
    n = 1;
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (state == 2'b01) instr_data = im;
      if (state[1]) instr_valid = 1'b0;
      if (wb_valid) break;
    end
    instr_valid = 1'b0;
    chk("wb_seen", {31'd0, wb_valid}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    vecs[0]  = '{8'hA1, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b0, 8'h02};
    vecs[1]  = '{8'h01, 1'b1, 8'hC0, 8'h1A, 1'b0, 1'b1, 8'h04};
    vecs[2]  = '{8'h20, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h05};
    vecs[3]  = '{8'hE1, 1'b1, 8'h10, 8'h00, 1'b1, 1'b0, B};
    vecs[4]  = '{8'hA9, 1'b1, 8'h0F, 8'h00, 1'b1, 1'b0, B + 8'd2};
    vecs[5]  = '{8'h62, 1'b0, 8'h00, 8'h0F, 1'b0, 1'b0, B + 8'd3};
    vecs[6]  = '{8'h41, 1'b1, 8'h3C, 8'h0C, 1'b0, 1'b0, B + 8'd5};
    vecs[7]  = '{8'h81, 1'b1, 8'h0C, 8'h00, 1'b1, 1'b0, B + 8'd7};
    vecs[8]  = '{8'h21, 1'b1, 8'h01, 8'hFF, 1'b0, 1'b1, B + 8'd9};
    vecs[9]  = '{8'h01, 1'b1, 8'h01, 8'h00, 1'b1, 1'b1, B + 8'd11};
    vecs[10] = '{8'hA2, 1'b0, 8'h00, 8'h0F, 1'b1, 1'b1, B + 8'd12};
    vecs[11] = '{8'h02, 1'b0, 8'h00, 8'h1E, 1'b0, 1'b0, B + 8'd13};
    vecs[12] = '{8'hE1, 1'b1, 8'h40, 8'h1E, 1'b0, 1'b0, B + 8'd15};
    vecs[13] = '{8'hC1, 1'b1, 8'h30, 8'h1E, 1'b0, 1'b0, 8'h30};
    vecs[14] = '{8'h80, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h31};
    vecs[15] = '{8'h0A, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h32};
    vecs[16] = '{8'hA2, 1'b0, 8'h00, 8'h1E, 1'b0, 1'b0, 8'h33};

    rst_n = 1'b0; instr_valid = 1'b0; instr_data = 8'h00;
    #3;
    chk("rst_pc", {24'd0, pc}, 32'h0);
    chk("rst_state", {30'd0, state}, 32'h0);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_wb", {31'd0, wb_valid}, 32'd0);
    chk("rst_out", {24'd0, out_data}, 32'h0);
    chk("rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      run_instr(vecs[i].op, vecs[i].im, n);
      chk($sformatf("v%0d_latency", i), n, vecs[i].hi ? 32'd4 : 32'd3);
      chk($sformatf("v%0d_out", i), {24'd0, out_data}, {24'd0, vecs[i].e_out});
      chk($sformatf("v%0d_z", i), {31'd0, flag_z}, {31'd0, vecs[i].e_z});
      chk($sformatf("v%0d_c", i), {31'd0, flag_c}, {31'd0, vecs[i].e_c});
      chk($sformatf("v%0d_pc", i), {24'd0, pc}, {24'd0, vecs[i].e_pc});
      chk($sformatf("v%0d_state", i), {30'd0, state}, 32'd0);
      chk($sformatf("v%0d_wb_low", i), {31'd0, wb_valid}, 32'd0);
    end

    // Stall in FETCH: nothing may move.
    repeat (5) @(negedge clk);
    chk("stallf_state", {30'd0, state}, 32'd0);
    chk("stallf_pc", {24'd0, pc}, 32'h33);
    chk("stallf_out", {24'd0, out_data}, 32'h1E);

    // JMP #0xFF with a stall in IMM, then one word at 0xFF wraps pc to 0.
    instr_data = 8'hC1; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("stalli_state", {30'd0, state}, 32'd1);
    chk("stalli_pc", {24'd0, pc}, 32'h34);
    chk("stalli_ready", {31'd0, instr_ready}, 32'd1);
    chk("stalli_out", {24'd0, out_data}, 32'h1E);
    run_instr(8'hFF, 8'hFF, n);
    chk("jmpff_pc", {24'd0, pc}, 32'hFF);
    instr_data = 8'h80; instr_valid = 1'b1;
    run_instr(8'h80, 8'h00, n);
    chk("wrap_latency", n, 32'd3);
    chk("wrap_pc", {24'd0, pc}, 32'h00);
    chk("wrap_out", {24'd0, out_data}, 32'h00);
    chk("wrap_z", {31'd0, flag_z}, 32'd1);

    run_instr(8'hA1, 8'h55, n);
    chk("mov55_out", {24'd0, out_data}, 32'h55);
    chk("mov55_pc", {24'd0, pc}, 32'h02);

    // ADD R0,#0x77 aborted by reset while in EXEC.
    instr_data = 8'h01; instr_valid = 1'b1;
    @(negedge clk);
    instr_data = 8'h77;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("exec_state", {30'd0, state}, 32'd2);
    chk("exec_ready", {31'd0, instr_ready}, 32'd0);
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rx_pc", {24'd0, pc}, 32'h0);
    chk("rx_out", {24'd0, out_data}, 32'h0);
    chk("rx_flags", {30'd0, flag_z, flag_c}, 32'd0);
    chk("rx_state", {30'd0, state}, 32'd0);
    chk("rx_ready", {31'd0, instr_ready}, 32'd1);
    chk("rx_wb", {31'd0, wb_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
